// File: rtl/frame_timing_pkg.sv
// Shared types and constants for the frame timing controller: FSM states,
// training-field geometry and the m_user sideband layout.
package frame_timing_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_LTF_GI,
        ST_LTF,
        ST_SYM_GI,
        ST_SYM
    } state_t;

    localparam int IDX_W             = 8;
    localparam int LTF_GI_LENGTH     = 32;
    localparam int LTF_BLOCKS        = 2;
    localparam int M_USER_SAMPLE_LSB = 0;
    localparam int M_USER_BLOCK_LSB  = 8;

    function automatic logic [31:0] pack_user(input logic [IDX_W-1:0] blk,
                                              input logic [IDX_W-1:0] smp);
        logic [31:0] u;
        u = '0;
        u[M_USER_BLOCK_LSB +: IDX_W]  = blk;
        u[M_USER_SAMPLE_LSB +: IDX_W] = smp;
        return u;
    endfunction

    // Terminal count for a run of len beats; a zero-length run never counts.
    function automatic logic [IDX_W-1:0] terminal_of(input int len);
        return (len > 0) ? IDX_W'(len - 1) : '0;
    endfunction

endpackage

// File: rtl/block_counter.sv
// Loadable counter that wraps to zero after reaching a run-time terminal value.
module block_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             inc,
    input  logic [WIDTH-1:0] terminal,
    output logic [WIDTH-1:0] count,
    output logic             at_terminal
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign count       = count_q;
    assign at_terminal = (count_q == terminal);

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (inc) begin
            count_d = at_terminal ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/frame_timing_controller.sv
// Cuts the post-sync sample stream into LTF and data-symbol blocks for the FFT.
// Optional feature macro: FRAME_TIMING_CONTROLLER_ABORT_EN enables the abort input.
module frame_timing_controller
    import frame_timing_pkg::*;
#(
    parameter int CP_LENGTH  = 16,
    parameter int FFT_LENGTH = 64,
    parameter int LTF_OFFSET = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic [31:0] s_user,
    input  logic        s_last,
    input  logic [7:0]  num_symbols,
    input  logic        abort,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic [31:0] m_user,
    output logic        m_last,
    output logic        freq_valid,
    output logic [31:0] freq_offset,
    output logic        busy
);

    localparam logic [IDX_W-1:0] ALIGN_TC       = terminal_of(LTF_OFFSET);
    localparam logic [IDX_W-1:0] LTF_GI_TC      = terminal_of(LTF_GI_LENGTH);
    localparam logic [IDX_W-1:0] CP_TC          = terminal_of(CP_LENGTH);
    localparam logic [IDX_W-1:0] FFT_TC         = terminal_of(FFT_LENGTH);
    localparam logic [IDX_W-1:0] LAST_LTF_BLOCK = IDX_W'(LTF_BLOCKS - 1);
    localparam state_t DETECT_NEXT = (LTF_OFFSET == 0) ? ST_LTF_GI : ST_ALIGN;
    localparam state_t SYM_ENTRY   = (CP_LENGTH == 0) ? ST_SYM : ST_SYM_GI;

    state_t      state_q, state_d;
    logic [7:0]  num_sym_q, num_sym_d;
    logic [31:0] freq_offset_q, freq_offset_d;
    logic        freq_valid_q, freq_valid_d;
    logic        m_valid_q, m_valid_d;
    logic [31:0] m_data_q, m_data_d;
    logic [31:0] m_user_q, m_user_d;
    logic        m_last_q, m_last_d;

    logic             pass_state;
    logic             accept;
    logic             load;
    logic             abort_hit;
    logic [7:0]       last_sym_blk;
    logic             smp_clear, smp_inc, smp_at_term;
    logic [IDX_W-1:0] smp_terminal, smp_count;
    logic             blk_clear, blk_inc;
    logic [IDX_W-1:0] blk_count;
    logic             unused_blk_term;

`ifdef FRAME_TIMING_CONTROLLER_ABORT_EN
    assign abort_hit = abort && (state_q != ST_IDLE);
`else
    logic unused_abort;
    assign unused_abort = abort;
    assign abort_hit    = 1'b0;
`endif

    // Sample counter: discard lengths in gap states, sample index in pass states.
    block_counter #(.WIDTH(IDX_W)) u_sample_counter (
        .clk         (clk),
        .reset       (reset),
        .load        (smp_clear),
        .load_value  ('0),
        .inc         (smp_inc),
        .terminal    (smp_terminal),
        .count       (smp_count),
        .at_terminal (smp_at_term)
    );

    block_counter #(.WIDTH(IDX_W)) u_block_counter (
        .clk         (clk),
        .reset       (reset),
        .load        (blk_clear),
        .load_value  ('0),
        .inc         (blk_inc),
        .terminal    ({IDX_W{1'b1}}),
        .count       (blk_count),
        .at_terminal (unused_blk_term)
    );

    assign pass_state   = (state_q == ST_LTF) || (state_q == ST_SYM);
    assign s_ready      = pass_state ? (!m_valid_q || m_ready) : 1'b1;
    assign accept       = s_valid && s_ready;
    assign last_sym_blk = num_sym_q + 8'd1;

    always_comb begin
        case (state_q)
            ST_ALIGN:  smp_terminal = ALIGN_TC;
            ST_LTF_GI: smp_terminal = LTF_GI_TC;
            ST_SYM_GI: smp_terminal = CP_TC;
            default:   smp_terminal = FFT_TC;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        num_sym_d     = num_sym_q;
        freq_offset_d = freq_offset_q;
        freq_valid_d  = 1'b0;
        load          = 1'b0;
        smp_clear     = 1'b0;
        smp_inc       = 1'b0;
        blk_clear     = 1'b0;
        blk_inc       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept && s_last) begin
                    freq_offset_d = s_user;
                    freq_valid_d  = 1'b1;
                    num_sym_d     = num_symbols;
                    smp_clear     = 1'b1;
                    blk_clear     = 1'b1;
                    state_d       = DETECT_NEXT;
                end
            end
            ST_ALIGN, ST_LTF_GI, ST_SYM_GI: begin
                if (accept) begin
                    smp_inc = 1'b1;
                    if (smp_at_term) begin
                        case (state_q)
                            ST_ALIGN:  state_d = ST_LTF_GI;
                            ST_LTF_GI: state_d = ST_LTF;
                            default:   state_d = ST_SYM;
                        endcase
                    end
                end
            end
            ST_LTF: begin
                if (accept) begin
                    load    = 1'b1;
                    smp_inc = 1'b1;
                    if (smp_at_term) begin
                        blk_inc = 1'b1;
                        if (blk_count == LAST_LTF_BLOCK) begin
                            state_d = (num_sym_q == 8'd0) ? ST_IDLE : SYM_ENTRY;
                        end
                    end
                end
            end
            ST_SYM: begin
                if (accept) begin
                    load    = 1'b1;
                    smp_inc = 1'b1;
                    if (smp_at_term) begin
                        blk_inc = 1'b1;
                        state_d = (blk_count == last_sym_blk) ? ST_IDLE : SYM_ENTRY;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A truncated block is simply cut off: nothing more is loaded.
        if (abort_hit) begin
            state_d = ST_IDLE;
            load    = 1'b0;
            smp_inc = 1'b0;
            blk_inc = 1'b0;
        end
    end

    always_comb begin
        m_valid_d = m_valid_q && !m_ready;
        m_data_d  = m_data_q;
        m_user_d  = m_user_q;
        m_last_d  = m_last_q;
        if (load) begin
            m_valid_d = 1'b1;
            m_data_d  = s_data;
            m_user_d  = pack_user(blk_count, smp_count);
            m_last_d  = smp_at_term;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            num_sym_q     <= '0;
            freq_offset_q <= '0;
            freq_valid_q  <= 1'b0;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            m_user_q      <= '0;
            m_last_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            num_sym_q     <= num_sym_d;
            freq_offset_q <= freq_offset_d;
            freq_valid_q  <= freq_valid_d;
            m_valid_q     <= m_valid_d;
            m_data_q      <= m_data_d;
            m_user_q      <= m_user_d;
            m_last_q      <= m_last_d;
        end
    end

    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_user      = m_user_q;
    assign m_last      = m_last_q;
    assign freq_valid  = freq_valid_q;
    assign freq_offset = freq_offset_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_frame_timing_controller.sv
// Scoreboard bench for frame_timing_controller: randomized frames, positional reference model.
module tb_frame_timing_controller;

    localparam int CP  = 16;
    localparam int FFT = 64;
    localparam int OFS = 8;
    localparam int GI  = 32;
    localparam int SKIP = OFS + GI;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid, s_ready, s_last, abort;
    logic [31:0] s_data, s_user;
    logic [7:0]  num_symbols;
    logic        m_valid, m_ready, m_last, freq_valid, busy;
    logic [31:0] m_data, m_user, freq_offset;

    always #5 clk = ~clk;

    frame_timing_controller #(
        .CP_LENGTH  (CP),
        .FFT_LENGTH (FFT),
        .LTF_OFFSET (OFS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_user      (s_user),
        .s_last      (s_last),
        .num_symbols (num_symbols),
        .abort       (abort),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_user      (m_user),
        .m_last      (m_last),
        .freq_valid  (freq_valid),
        .freq_offset (freq_offset),
        .busy        (busy)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] user;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] freq_q[$];
    int vectors = 0;
    int errors  = 0;
    int bp_pct  = 100;
    int bubble_pct = 0;

`ifdef FRAME_TIMING_CONTROLLER_ABORT_EN
    localparam bit ABORT_ON = 1'b1;
`else
    localparam bit ABORT_ON = 1'b0;
`endif

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Position k counts beats after the detect beat.
    function automatic bit ref_pos(input int k, input int n, output logic [7:0] blk,
                                   output logic [7:0] smp);
        int p;
        blk = 8'd0;
        smp = 8'd0;
        p = k - SKIP;
        if (p < 0) return 1'b0;
        if (p < 2 * FFT) begin
            blk = 8'(p / FFT);
            smp = 8'(p % FFT);
            return 1'b1;
        end
        p = p - 2 * FFT;
        if (p >= n * (CP + FFT)) return 1'b0;
        if ((p % (CP + FFT)) < CP) return 1'b0;
        blk = 8'(2 + p / (CP + FFT));
        smp = 8'((p % (CP + FFT)) - CP);
        return 1'b1;
    endfunction

    task automatic drive(input logic [31:0] d, input logic lst, input logic [31:0] u,
                         input logic [7:0] ns, input logic ab, output bit acc);
        int tries;
        tries = 0;
        acc = 1'b0;
        while (!acc) begin
            @(negedge clk);
            s_valid     = ($urandom_range(99) >= bubble_pct);
            s_data      = d;
            s_last      = lst;
            s_user      = u;
            num_symbols = ns;
            abort       = ab && s_valid;
            m_ready     = ($urandom_range(99) < bp_pct);
            #1;
            acc = s_valid && s_ready;
            tries++;
            if (!acc && tries > 500) begin
                chk("beat_accept_timeout", 96'd0, 96'd1);
                break;
            end
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        abort   = 1'b0;
        m_ready = ($urandom_range(99) < bp_pct);
    endtask

    task automatic run_frame(input int n, input logic [31:0] u, input int redet_at,
                             input int abort_at, input int reset_at);
        bit acc;
        logic [7:0] blk, smp;
        logic [31:0] d;
        int len;
        drive($urandom, 1'b1, u, 8'(n), 1'b0, acc);
        if (acc) freq_q.push_back(u);
        len = SKIP + 2 * FFT + n * (CP + FFT);
        for (int k = 0; k < len; k++) begin
            if (k == reset_at) begin
                @(negedge clk);
                s_valid = 1'b0;
                m_ready = 1'b1;
                reset   = 1'b1;
                @(negedge clk);
                #1;
                chk("rst_m_valid", m_valid, 0);
                chk("rst_m_last", m_last, 0);
                chk("rst_freq_valid", freq_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_m_data", m_data, 0);
                chk("rst_m_user", m_user, 0);
                chk("rst_freq_offset", freq_offset, 0);
                reset = 1'b0;
                exp_q.delete();
                return;
            end
            d = $urandom;
            drive(d, (k == redet_at), $urandom, 8'($urandom), (k == abort_at), acc);
            if (k == 0) chk("busy_in_frame", busy, 1);
            if (k == abort_at && ABORT_ON) begin
                @(negedge clk);
                s_valid = 1'b0;
                abort   = 1'b0;
                #1;
                chk("busy_after_abort", busy, 0);
                return;
            end
            if (acc && ref_pos(k, n, blk, smp))
                exp_q.push_back('{d, {16'h0, blk, smp}, (smp == 8'(FFT - 1))});
        end
    endtask

    task automatic finish_frame(input logic [31:0] u);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            idle_cycle();
            t++;
        end
        chk("drain_outputs_left", exp_q.size(), 0);
        repeat (3) idle_cycle();
        #1;
        chk("busy_at_end", busy, 0);
        chk("m_valid_at_end", m_valid, 0);
        chk("freq_pulses_left", freq_q.size(), 0);
        chk("freq_offset_held", freq_offset, u);
    endtask

    // Monitor: pops expected beats whenever the output handshake completes.
    initial begin
        bit          stall;
        logic [31:0] sd, su;
        logic        sl;
        beat_t       e;
        stall = 1'b0;
        sd = '0;
        su = '0;
        sl = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                stall = 1'b0;
                continue;
            end
            if (stall)
                chk("stall_hold", {m_valid, m_data, m_user, m_last}, {1'b1, sd, su, sl});
            if (m_valid && m_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got data %h user %h last %b, required no output",
                             m_data, m_user, m_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_data, m_user, m_last} !== e) begin
                        errors++;
                        $display("FAIL out_beat: got data %h user %h last %b expected data %h user %h last %b",
                                 m_data, m_user, m_last, e.data, e.user, e.last);
                    end
                end
            end
            stall = m_valid && !m_ready;
            sd = m_data;
            su = m_user;
            sl = m_last;
            if (freq_valid) begin
                if (freq_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL freq_pulse: got pulse with offset %h, required none", freq_offset);
                end else begin
                    chk("freq_offset", freq_offset, freq_q.pop_front());
                end
            end
        end
    end

    initial begin
        bit acc;
        reset = 1'b1;
        s_valid = 1'b0;
        s_last = 1'b0;
        abort = 1'b0;
        m_ready = 1'b1;
        s_data = '0;
        s_user = '0;
        num_symbols = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_m_valid", m_valid, 0);
        chk("reset_m_last", m_last, 0);
        chk("reset_freq_valid", freq_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_m_data", m_data, 0);
        chk("reset_m_user", m_user, 0);
        chk("reset_freq_offset", freq_offset, 0);
        chk("reset_s_ready", s_ready, 1);

        // Basic frame
        run_frame(2, 32'h0000_0123, -1, -1, -1);
        finish_frame(32'h0000_0123);

        // Backpressure with input bubbles
        bp_pct = 30;
        bubble_pct = 10;
        run_frame(2, 32'h0000_0123, -1, -1, -1);
        finish_frame(32'h0000_0123);
        bp_pct = 100;
        bubble_pct = 0;

        // Zero data symbols
        run_frame(0, 32'hFFFF_FE01, -1, -1, -1);
        finish_frame(32'hFFFF_FE01);

        // Ignored re-detect mid-SYM, then back-to-back detect
        run_frame(2, 32'h1111_2222, SKIP + 2 * FFT + CP + 10, -1, -1);
        run_frame(1, 32'h3333_4444, -1, -1, -1);
        finish_frame(32'h3333_4444);

        // Abort at sample 30 of block 2, then non-detect beats must be dropped
        run_frame(2, 32'h5555_6666, -1, SKIP + 2 * FFT + CP + 31, -1);
        for (int i = 0; i < 20; i++) drive($urandom, 1'b0, $urandom, 8'd3, 1'b0, acc);
        finish_frame(32'h5555_6666);

        // Reset in the middle of LTF, then a clean frame
        run_frame(2, 32'h7777_8888, -1, -1, SKIP + 50);
        freq_q.delete();
        repeat (2) idle_cycle();
        run_frame(1, 32'h0000_0abc, -1, -1, -1);
        finish_frame(32'h0000_0abc);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/frame_timing_controller.md
# frame_timing_controller

Sequences the sample stream leaving the preamble synchronization stage into OFDM symbol blocks for the FFT. On the frame-detect marker (`s_last`) it latches the coarse frequency offset for the derotator, skips the alignment gap and the long-training guard interval, and passes the two 64-sample LTF blocks. It then strips the cyclic prefix from each data symbol and forwards exactly `FFT_LENGTH` samples per symbol for a programmed symbol count. It sits between `synchronization` and the derotator/FFT.

## Interface
- `CP_LENGTH`, 16, cyclic-prefix samples discarded before each data symbol
- `FFT_LENGTH`, 64, samples forwarded per block; power of two, at most 256
- `LTF_OFFSET`, 8, samples discarded after the detect beat before the LTF guard interval; 0 is legal
- `clk` input 1: single clock
- `reset` input 1: synchronous, active-high
- `s_valid` input 1 / `s_ready` output 1: upstream handshake
- `s_data` input 32: sample, `{Q[15:0], I[15:0]}`
- `s_user` input 32: signed frequency-offset estimate
- `s_last` input 1: frame-detect marker
- `num_symbols` input 8: data symbols per frame; sampled on the detect beat
- `abort` input 1: terminate the current frame
- `m_valid` output 1 / `m_ready` input 1: downstream handshake
- `m_data` output 32: forwarded sample
- `m_user` output 32: `{16'b0, block_index[7:0], sample_index[7:0]}`
- `m_last` output 1: high on the final sample of each block
- `freq_valid` output 1: single-cycle pulse when `freq_offset` updates
- `freq_offset` output 32: latched `s_user` from the detect beat
- `busy` output 1: high in every state except IDLE

## Operation
- **States:** IDLE, ALIGN, LTF_GI, LTF, SYM_GI, SYM.
- **IDLE:**
  - `s_ready`=1; samples are discarded.
  - An accepted beat with `s_last`=1 latches `freq_offset`, pulses `freq_valid`, latches `num_symbols`, clears the block counter and moves to ALIGN.
  - When `LTF_OFFSET`=0 it moves directly to LTF_GI.
- **Discard states:** ALIGN (`LTF_OFFSET` beats), LTF_GI (32 beats) and SYM_GI (`CP_LENGTH` beats).
  - `s_ready`=1; each accepted beat increments the sample counter.
  - At the terminal count the counter clears and the state advances: ALIGN→LTF_GI, LTF_GI→LTF, SYM_GI→SYM.
- **Pass states:** LTF (2×`FFT_LENGTH` beats, block indices 0 and 1) and SYM (`FFT_LENGTH` beats, block indices 2…`num_symbols`+1).
  - Each accepted beat loads the output register.
  - `sample_index` counts 0…`FFT_LENGTH`-1 and wraps.
  - `m_last` is set on index `FFT_LENGTH`-1.
- **Frame end:**
  - After the last LTF beat, go to SYM_GI, or to IDLE when the latched count is 0.
  - After each SYM block, go to SYM_GI while blocks remain, otherwise to IDLE.
- **Ignored `s_last`:** `s_last` outside IDLE has no effect; a new detection during a frame is dropped.
- **Abort:**
  - Takes effect on the edge after `abort` is sampled high; the next state is IDLE.
  - An output beat already in the register stays until accepted.
  - No further beats are loaded, and no `m_last` is synthesized for a truncated block.
  - `abort` in IDLE has no effect.
  - If `abort` coincides with a detect beat in IDLE, detection wins.
- **Arithmetic:** counters are 8-bit unsigned; block index wraps modulo 256. `freq_offset` is passed unmodified.

## Timing
- **Reset values:** `m_valid`, `m_last`, `freq_valid` and `busy` are 0; `m_data`, `m_user` and `freq_offset` are 0; state is IDLE.
- **Pass-state handshake:**
  - Latency is one cycle from accepted input to `m_valid`.
  - `s_ready` = `!m_valid || m_ready`, so full throughput is sustained with `m_ready` held high.
  - `m_data`, `m_user` and `m_last` are stable while `m_valid && !m_ready`.
- **Pass→discard transitions:**
  - `s_ready` stays 1 in discard states; the pending output beat drains independently.
  - A discard state never loads the output register.
- **Detect beat:** `freq_valid` asserts the cycle after the detect beat is accepted.
- **`busy`:** rises the cycle after the detect beat and falls the cycle the state returns to IDLE.
- **Reset mid-frame:** reset overrides everything and drops the pending output beat.

## Configuration
- **Macro:** `FRAME_TIMING_CONTROLLER_ABORT_EN`.
- **Defined:** `abort` behaves as described above.
- **Undefined:** the `abort` port remains but is ignored. A frame then ends only by completion or `reset`.

## Structure
- **Shared package:** `frame_timing_pkg` holds the state enum, `LTF_GI_LENGTH`=32, `LTF_BLOCKS`=2 and the `m_user` field layout (block/sample index offsets).
- **Sub-module:** one, `block_counter`, a loadable terminal-count counter with wrap. It is instantiated for sample index and block index.

## Test plan
- **Basic frame:** defaults, `num_symbols`=2, continuous stream with detect marker and `s_user`=0x0000_0123.
  - `freq_offset`=0x123 with one `freq_valid` pulse.
  - 40 samples are discarded.
  - 128 LTF beats (blocks 0,1) are forwarded, then for each of blocks 2,3: 16 discarded, 64 forwarded.
  - `m_last` on every 64th output; `busy` then falls.
- **Backpressure:** same stimulus with random `m_ready` at 30% duty. Output sequence is identical to the basic frame, with no drop or duplicate and outputs stable while stalled.
- **Zero symbols:** `num_symbols`=0. Exactly 128 outputs; IDLE after LTF block 1.
- **Ignored re-detect:** a second `s_last` during SYM has no effect. A detect beat one cycle after return to IDLE starts a new frame with block index 0.
- **Abort:** `abort` at output sample 30 of block 2. Output stops after the pending beat, with no `m_last` and `busy` low the next cycle. With the macro undefined, the frame completes normally.
- **Reset mid-LTF:** `reset` asserted. All outputs return to their reset values the next cycle.
